// File: rtl/rr_arb8_pkg.sv
// Shared types and constants for the eight-way round-robin arbiter.
// Also holds the rotating-priority pick used in the IDLE state.
package rr_arb8_pkg;

    typedef enum logic [0:0] {IDLE, GRANT} state_e;

    localparam int unsigned NREQ      = 8;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Rotate req right by ptr, take the lowest set bit, then undo the rotation.
    // Caller guarantees req is non-zero; an all-zero req returns ptr.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [2:0] ptr);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [2:0]        off;
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        return off + ptr;
    endfunction

endpackage

// File: rtl/bcd7seg.sv
// Hex digit to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
module bcd7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'b1111111;
        unique case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/rr_arb8.sv
// Round-robin arbiter for eight requesters with done/drop/timeout release
// and a seven-segment display of the current grant holder.
module rr_arb8
    import rr_arb8_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [2:0]      gnt_id,
    output logic [6:0]      seg,
    output logic [7:0]      grant_cnt
);

    localparam bit         TimeoutEn   = (TIMEOUT != 0);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [2:0]      gnt_id_q, gnt_id_d;
    logic [7:0]      timer_q, timer_d;
    logic [7:0]      grant_cnt_q, grant_cnt_d;

    logic [2:0]      pick;
    logic            timeout_hit;
    logic [6:0]      seg_dec;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        timer_d     = timer_q;
        grant_cnt_d = grant_cnt_q;
        pick        = rr_pick(req, ptr_q);
        timeout_hit = TimeoutEn && (timer_q == TimeoutLast);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d       = NREQ'(1) << pick;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = pick;
                    timer_d     = '0;
                    grant_cnt_d = grant_cnt_q + 8'd1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Only the holder's own request line matters while granted.
                if (done || !req[gnt_id_q] || timeout_hit) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_id_q + 3'd1;
                    state_d     = IDLE;
                end else if (timer_q != 8'hFF) begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timer_q     <= '0;
            grant_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timer_q     <= timer_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    bcd7seg u_bcd7seg (
        .hex_i ({1'b0, gnt_id_q}),
        .seg_o (seg_dec)
    );

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign grant_cnt = grant_cnt_q;
    assign seg       = gnt_valid_q ? seg_dec : SEG_BLANK;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: directed vector table, hand-written corner sequences and
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_rr_arb8;

    localparam int unsigned T = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_id;
    logic [6:0] seg;
    logic [7:0] grant_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who holds the resource and for how many cycles so far.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_len   = 0;
    int m_cnt   = 0;

    logic [6:0] segtab [8];

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] id;
        logic [7:0] cnt;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs [9];

    rr_arb8 #(
        .TIMEOUT (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .seg       (seg),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q, input logic d);
        if (r) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_len = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (q != 8'h00) begin
                for (int k = 7; k >= 0; k--) begin
                    if (q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
                end
                m_busy = 1'b1;
                m_len  = 1;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (d || !q[m_owner] || (T != 0 && m_len == int'(T))) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 8;
        end else begin
            m_len++;
        end
    endtask

    task automatic model_check();
        chk("model_gnt", gnt, m_busy ? 8'(1 << m_owner) : 8'h00);
        chk("model_valid", 8'(gnt_valid), 8'(m_busy));
        chk("model_id", 8'(gnt_id), 8'(m_owner));
        chk("model_seg", 8'(seg), m_busy ? 8'(segtab[m_owner]) : 8'h7F);
        chk("model_cnt", grant_cnt, 8'(m_cnt));
    endtask

    // Drive inputs, let the DUT sample them at the next edge, then check #1 later.
    task automatic cycle(input logic r, input logic [7:0] q, input logic d);
        rst = r; req = q; done = d;
        @(posedge clk);
        #1;
        model_step(r, q, d);
        model_check();
    endtask

    initial begin
        logic [7:0] rq;
        logic       d;

        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001;
        segtab[2] = 7'b0100100; segtab[3] = 7'b0110000;
        segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000;

        // Reset, basic grant/release, then request drop with pointer wrap.
        vecs[0] = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 8'd0, 7'h7F};
        vecs[1] = '{1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 8'd0, 7'h7F};
        vecs[2] = '{1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 8'd1, 7'h40};
        vecs[3] = '{1'b0, 8'h81, 1'b1, 8'h00, 3'd0, 8'd1, 7'h7F};
        vecs[4] = '{1'b0, 8'h81, 1'b0, 8'h80, 3'd7, 8'd2, 7'h78};
        vecs[5] = '{1'b0, 8'h09, 1'b0, 8'h00, 3'd7, 8'd2, 7'h7F};
        vecs[6] = '{1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 8'd3, 7'h40};
        vecs[7] = '{1'b0, 8'h09, 1'b1, 8'h00, 3'd0, 8'd3, 7'h7F};
        vecs[8] = '{1'b0, 8'h09, 1'b0, 8'h08, 3'd3, 8'd4, 7'h30};

        for (int i = 0; i < 9; i++) begin
            cycle(vecs[i].rst, vecs[i].req, vecs[i].done);
            chk($sformatf("vec%0d_gnt", i), gnt, vecs[i].gnt);
            chk($sformatf("vec%0d_valid", i), 8'(gnt_valid), 8'(|vecs[i].gnt));
            chk($sformatf("vec%0d_id", i), 8'(gnt_id), 8'(vecs[i].id));
            chk($sformatf("vec%0d_cnt", i), grant_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_seg", i), 8'(seg), 8'(vecs[i].seg));
        end

        // Reset in the middle of a grant to id 5.
        cycle(1'b1, 8'h00, 1'b0);
        cycle(1'b0, 8'h20, 1'b0);
        chk("mid_pre_id", 8'(gnt_id), 8'd5);
        cycle(1'b1, 8'h21, 1'b0);
        chk("mid_rst_gnt", gnt, 8'h00);
        chk("mid_rst_id", 8'(gnt_id), 8'd0);
        chk("mid_rst_cnt", grant_cnt, 8'd0);
        chk("mid_rst_seg", 8'(seg), 8'h7F);
        cycle(1'b0, 8'h21, 1'b0);
        chk("mid_after_gnt", gnt, 8'h01);

        // Timeout only: four cycles granted, one idle, repeating.
        cycle(1'b1, 8'h00, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            cycle(1'b0, 8'h04, 1'b0);
            chk($sformatf("tmo_c%0d", c), gnt, (c % 5 != 0) ? 8'h04 : 8'h00);
        end
        chk("tmo_cnt", grant_cnt, 8'd3);

        // Fairness: all request, done on every granted cycle.
        cycle(1'b1, 8'hFF, 1'b0);
        for (int c = 1; c <= 19; c++) begin
            d = m_busy;
            cycle(1'b0, 8'hFF, d);
            if (c % 2 == 1) begin
                chk($sformatf("fair_id_c%0d", c), 8'(gnt_id), 8'(((c - 1) / 2) % 8));
                chk($sformatf("fair_valid_c%0d", c), 8'(gnt_valid), 8'd1);
            end else begin
                chk($sformatf("fair_idle_c%0d", c), 8'(gnt_valid), 8'd0);
            end
        end
        chk("fair_cnt", grant_cnt, 8'd10);

        // Random traffic against the model.
        rq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rq = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
            end
            d = ($urandom_range(0, 7) == 0);
            cycle($urandom_range(0, 99) == 0, rq, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arb8.md
# rr_arb8

Round-robin arbiter that shares one resource among eight requesters and shows the current winner on a seven-segment digit. Each requester raises a request line and holds the resource until it signals done, drops its request, or exceeds a configurable hold limit. The block sits between the board's switch/button inputs and the shared datapath, and drives one display digit through the existing `bcd7seg` decoder.

## Interface
- `TIMEOUT`, default 16: maximum grant length in cycles, legal range 1..255; 0 disables the timeout.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  8  request lines; `req[i]` is requester i.
- `done`  in  1  the current grant holder releases the resource.
- `gnt`  out  8  one-hot grant; all zeros when idle.
- `gnt_valid`  out  1  high while any grant is held.
- `gnt_id`  out  3  index of the current or most recent grant holder.
- `seg`  out  7  active-low segment pattern; shows hex `{1'b0,gnt_id}` when `gnt_valid` is high, otherwise 7'b1111111 (blank).
- `grant_cnt`  out  8  count of grants issued; wraps from 255 to 0.

## Operation
- Registered state: FSM state (IDLE, GRANT), `ptr[2:0]`, `gnt`, `gnt_id`, `timer[7:0]`, `grant_cnt`.
- Reset values:
  - state IDLE, `ptr` 0, `gnt` 0, `gnt_valid` 0, `gnt_id` 0, `timer` 0, `grant_cnt` 0.
  - `seg` is 7'b1111111 while reset holds the block idle.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise select the first set bit scanning `ptr`, `ptr+1`, … `ptr+7` (mod 8).
  - Load `gnt` with that one-hot value and `gnt_id` with its index.
  - Clear `timer`, increment `grant_cnt`, go to GRANT.
- GRANT: release at the edge where any of these is true:
  - `done` is 1;
  - `req[gnt_id]` is 0;
  - `TIMEOUT != 0` and `timer == TIMEOUT-1`.
- On release:
  - `gnt` goes to 0 and state returns to IDLE.
  - `ptr` becomes `gnt_id+1` (mod 8; 7 wraps to 0).
  - `gnt_id` keeps its value.
- Without a release, `timer` increments while in GRANT and saturates at 255.
- Simultaneous events:
  - `done` together with other requests: release first. Arbitration happens on the next IDLE cycle, so there is always one idle bubble.
  - Requests from other indices never preempt a grant.
  - `req` changes during GRANT are ignored except for `req[gnt_id]`.
- `rst` takes priority over all other inputs. Reset mid-grant drops `gnt` at that edge and restores `ptr` to 0.
- `gnt_valid` equals the OR of `gnt`. `gnt` is always zero or one-hot.

## Timing
- Request to grant: 1 cycle. `req` is sampled at edge t in IDLE and `gnt` is visible after edge t.
- Release: a condition sampled at edge k deasserts `gnt` after edge k. The earliest next grant is after edge k+1.
- Maximum grant length is exactly `TIMEOUT` cycles of `gnt` high. `TIMEOUT`=1 gives single-cycle grants.
- Back-to-back grant period for one requester holding `req` with timeout only: `TIMEOUT`+1 cycles.
- `seg` is combinational from registered `gnt_valid`/`gnt_id`, so it changes in the same cycle as `gnt`.
- `grant_cnt` updates on the same edge that asserts `gnt`.

## Structure
- Shared package holds:
  - state enum {IDLE, GRANT};
  - constant `NREQ` = 8;
  - constant `SEG_BLANK` = 7'b1111111.
- Rotating priority pick: a function or combinational block that rotates `req` right by `ptr`, finds the lowest set bit, and adds `ptr` back mod 8.
- One sub-module instance: the existing `bcd7seg`, fed `{1'b0,gnt_id}`. Its output is muxed with `SEG_BLANK` on `gnt_valid`.

## Test plan
- Reset: assert `rst` 2 cycles with `req`=8'hFF. Required: `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `grant_cnt`=0, `seg`=7'b1111111 throughout.
- Basic grant/release: `req`=8'b1000_0001 from reset.
  - After 1 edge: `gnt`=8'h01, `seg`=7'b1000000.
  - Pulse `done`: `gnt`=0 for one cycle, then `gnt`=8'h80, `gnt_id`=7, `seg`=7'b1111000.
- Fairness: `req`=8'hFF held, `done` pulsed on each granted cycle. Required: `gnt_id` sequence 0,1,…,7,0,1 with an idle cycle between grants; `grant_cnt`=10 after 10 grants.
- Timeout (`TIMEOUT`=4): `req`=8'h04 held, `done`=0. Required: `gnt`=8'h04 for exactly 4 cycles, 1 idle cycle, then a re-grant to id 2; repeats with period 5.
- Request drop and wrap: grant id 7, then drop `req[7]` with `req`=8'h09 remaining. Required: release on the next edge, `ptr` wraps to 0, next grant is id 0, then id 3.
- Reset mid-grant: `rst` high during GRANT of id 5 with `req`=8'h21. Required: all outputs at reset values after that edge; after `rst` drops, first grant is id 0 (`ptr`=0).
